// File: rtl/gamma_correction_pipe_if.sv
// Pixel stream bundle for the gamma stage: upstream valid/ready with per-pixel
// brightness and bypass, downstream valid/ready with the corrected pixel.
interface gamma_correction_pipe_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CW       = 8
);
  logic [CHANNELS*CW-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [CW-1:0]          bright;
  logic                   bypass;
  logic [CHANNELS*CW-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, bright, bypass, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, bright, bypass, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/gamma_correction_pipe.sv
// Two-stage gamma/brightness pipe: S1 maps each channel through a shared writable
// LUT (identity after reset), S2 scales by (bright + 1) / 2^CW.
module gamma_correction_pipe #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CW       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gamma_correction_pipe_if.slave pix,
  input  logic                  lut_we,
  input  logic [CW-1:0]         lut_addr,
  input  logic [CW-1:0]         lut_wdata
);
  localparam int unsigned Entries = 2 ** CW;
  localparam int unsigned PW      = CHANNELS * CW;

  logic [CW-1:0] lut_q [Entries];
  logic [CW-1:0] lut_d [Entries];

  logic          en1, en2, accept;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [PW-1:0] g_q, g_d, out_q, out_d;
  logic [CW-1:0] br_q, br_d;

  // The product is 2*CW+1 bits; after the shift only the low CW bits can be set.
  function automatic logic [CW-1:0] scale(input logic [CW-1:0] g, input logic [CW-1:0] b);
    logic [2*CW:0] prod;
    prod = {(CW + 1)'(0), g} * {CW'(0), ({1'b0, b} + (CW + 1)'(1))};
    return CW'(prod >> CW);
  endfunction

  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_addr] = lut_wdata;
  end

  always_comb begin
    en2    = !v2_q || pix.out_ready;
    en1    = !v1_q || en2;
    accept = pix.in_valid && en1;

    v1_d = en1 ? pix.in_valid : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    g_d  = g_q;
    br_d = br_q;
    out_d = out_q;

    // LUT reads see lut_q, so a same-cycle write only affects later pixels.
    if (accept) begin
      br_d = pix.bright;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        g_d[k*CW +: CW] = pix.bypass ? pix.in_data[k*CW +: CW]
                                     : lut_q[pix.in_data[k*CW +: CW]];
      end
    end

    // Bubbles leave the output data register holding its last value.
    if (en2 && v1_q) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        out_d[k*CW +: CW] = scale(g_q[k*CW +: CW], br_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Entries); i++) lut_q[i] <= CW'(i);
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      g_q   <= '0;
      br_q  <= '0;
      out_q <= '0;
    end else begin
      lut_q <= lut_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      g_q   <= g_d;
      br_q  <= br_d;
      out_q <= out_d;
    end
  end

  assign pix.in_ready  = en1;
  assign pix.out_data  = out_q;
  assign pix.out_valid = v2_q;
endmodule
